// File: rtl/qspi_emu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qspi_emu_pkg
// Brief    : Shared states, command codes and helpers for the QSPI emulator.
// Revision : 1.0 - initial release
// ============================================================================
package qspi_emu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_RDATA = 3'd4,
    ST_WDATA = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam logic [7:0] CMD_READ_QUAD  = 8'hEB;
  localparam logic [7:0] CMD_WRITE_QUAD = 8'h02;
  localparam int         CMD_NIBBLES    = 2;
  localparam int         ADDR_NIBBLES   = 6;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    pop4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // Index of the lowest set bit; only meaningful when exactly one bit is set.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) low_idx = 2'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/qspi_emu_mem.sv
`default_nettype none
// ============================================================================
// Module   : qspi_emu_mem
// Brief    : Per-select byte storage with one read port, a QSPI write port and
//            a backdoor write; the QSPI write wins on a same-byte collision.
// Revision : 1.0 - initial release
// ============================================================================
module qspi_emu_mem #(
  parameter int NUM_CS = 3,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [1:0]        i_rd_sel,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data,
  input  logic              i_wr_en,
  input  logic [1:0]        i_wr_sel,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic              i_bd_we,
  input  logic [1:0]        i_bd_sel,
  input  logic [ADDR_W-1:0] i_bd_addr,
  input  logic [7:0]        i_bd_wdata
);

  localparam int         DEPTH    = NUM_CS << ADDR_W;
  localparam logic [2:0] c_NUM_CS = 3'(NUM_CS);

  logic [7:0] r_mem [DEPTH];
  logic       w_bd_ok;

  assign w_bd_ok = i_bd_we && ({1'b0, i_bd_sel} < c_NUM_CS);

  // Later assignment takes priority, so a colliding QSPI write overrides.
  always_ff @(posedge clk) begin
    if (w_bd_ok) r_mem[{i_bd_sel, i_bd_addr}] <= i_bd_wdata;
    if (i_wr_en) r_mem[{i_wr_sel, i_wr_addr}] <= i_wr_data;
  end

  assign o_rd_data = r_mem[{i_rd_sel, i_rd_addr}];

endmodule
`default_nettype wire

// File: rtl/qspi_mem_emu.sv
`default_nettype none
// ============================================================================
// Module   : qspi_mem_emu
// Brief    : Oversampling quad-SPI flash/RAM emulator with backdoor preload.
// Revision : 1.0 - initial release
// ============================================================================
module qspi_mem_emu
  import qspi_emu_pkg::*;
#(
  parameter int NUM_CS      = 3,
  parameter int ADDR_W      = 12,
  parameter int FLASH_DUMMY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_qspi_sck,
  input  logic [NUM_CS-1:0] i_qspi_cs_n,
  input  logic [3:0]        i_qspi_d_in,
  output logic [3:0]        o_qspi_d_out,
  output logic              o_qspi_d_oe,
  input  logic [2:0]        i_latency_cfg,
  input  logic              i_bd_we,
  input  logic [1:0]        i_bd_sel,
  input  logic [ADDR_W-1:0] i_bd_addr,
  input  logic [7:0]        i_bd_wdata,
  output logic              o_proto_err
);

  localparam int                SH_W          = ADDR_W - 4;
  localparam logic [2:0]        c_CMD_LAST    = 3'(CMD_NIBBLES - 1);
  localparam logic [2:0]        c_ADDR_LAST   = 3'(ADDR_NIBBLES - 1);
  localparam logic [2:0]        c_FLASH_DUMMY = 3'(FLASH_DUMMY);
  localparam logic [NUM_CS-1:0] c_CS_ONE      = NUM_CS'(1);

  state_t              r_state, w_state_nxt;
  logic                r_sck_q;
  logic [NUM_CS-1:0]   r_cs_q;
  logic [1:0]          r_dev;
  logic [2:0]          r_cnt, r_dummy;
  logic [SH_W-1:0]     r_shift;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_is_wr, r_wr_ign, r_phase;
  logic [3:0]          r_wnib, r_dout;
  logic                r_oe, r_err;

  logic                w_rise, w_fall, w_other_fall, w_desel;
  logic [NUM_CS-1:0]   w_cs_fall, w_dev_mask;
  logic [3:0]          w_act4;
  logic [7:0]          w_cmd, w_wr_data, w_rd_data;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_wr_en, w_set_err;

  assign w_rise       = i_qspi_sck & ~r_sck_q;
  assign w_fall       = ~i_qspi_sck & r_sck_q;
  assign w_cs_fall    = r_cs_q & ~i_qspi_cs_n;
  assign w_dev_mask   = c_CS_ONE << r_dev;
  assign w_other_fall = |(w_cs_fall & ~w_dev_mask);
  assign w_desel      = |(i_qspi_cs_n & w_dev_mask);
  assign w_cmd        = {r_shift[3:0], i_qspi_d_in};
  assign w_addr       = {r_shift, i_qspi_d_in};
  assign w_wr_data    = {r_wnib, i_qspi_d_in};

  always_comb begin
    w_act4             = '0;
    w_act4[NUM_CS-1:0] = ~i_qspi_cs_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_set_err   = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_cs_fall) begin
          if (pop4(w_act4) == 3'd1) begin
            w_state_nxt = ST_CMD;
          end else begin
            w_state_nxt = ST_ERR;
            w_set_err   = 1'b1;
          end
        end
      end
      ST_ERR: begin
        if (&i_qspi_cs_n) w_state_nxt = ST_IDLE;
      end
      default: begin
        if (w_other_fall) begin
          w_state_nxt = ST_ERR;
          w_set_err   = 1'b1;
        end else if (w_desel) begin
          w_state_nxt = ST_IDLE;
        end else begin
          case (r_state)
            ST_CMD: begin
              if (w_rise && r_cnt == c_CMD_LAST) begin
                if (w_cmd == CMD_READ_QUAD || w_cmd == CMD_WRITE_QUAD) begin
                  w_state_nxt = ST_ADDR;
                end else begin
                  w_state_nxt = ST_ERR;
                  w_set_err   = 1'b1;
                end
              end
            end
            ST_ADDR: begin
              if (w_rise && r_cnt == c_ADDR_LAST) begin
                if (r_is_wr)             w_state_nxt = ST_WDATA;
                else if (r_dummy != 3'd0) w_state_nxt = ST_DUMMY;
                else                     w_state_nxt = ST_RDATA;
              end
            end
            ST_DUMMY: begin
              if (w_rise && r_cnt == 3'd1) w_state_nxt = ST_RDATA;
            end
            ST_WDATA: begin
              w_wr_en = w_rise && r_phase && !r_wr_ign;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_q  <= 1'b0;
      r_cs_q   <= '1;
      r_dev    <= 2'd0;
      r_cnt    <= 3'd0;
      r_dummy  <= 3'd0;
      r_shift  <= '0;
      r_addr   <= '0;
      r_is_wr  <= 1'b0;
      r_wr_ign <= 1'b0;
      r_phase  <= 1'b0;
      r_wnib   <= 4'd0;
      r_oe     <= 1'b0;
      r_dout   <= 4'd0;
      r_err    <= 1'b0;
    end else begin
      r_sck_q <= i_qspi_sck;
      r_cs_q  <= i_qspi_cs_n;
      if (w_set_err) r_err <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_state_nxt == ST_CMD) begin
            r_dev   <= low_idx(w_act4);
            r_cnt   <= 3'd0;
            r_dummy <= (low_idx(w_act4) == 2'd0) ? c_FLASH_DUMMY : i_latency_cfg;
          end
        end
        ST_CMD: begin
          if (w_rise) begin
            r_shift <= {r_shift[SH_W-5:0], i_qspi_d_in};
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == c_CMD_LAST) begin
              r_cnt    <= 3'd0;
              r_is_wr  <= (w_cmd == CMD_WRITE_QUAD);
              r_wr_ign <= (r_dev == 2'd0);
            end
          end
        end
        ST_ADDR: begin
          if (w_rise) begin
            r_shift <= {r_shift[SH_W-5:0], i_qspi_d_in};
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == c_ADDR_LAST) begin
              r_addr  <= w_addr;
              r_cnt   <= r_dummy;
              r_phase <= 1'b0;
            end
          end
        end
        ST_DUMMY: begin
          if (w_rise) r_cnt <= r_cnt - 3'd1;
        end
        ST_RDATA: begin
          if (w_fall) begin
            r_phase <= ~r_phase;
            if (r_phase) r_addr <= r_addr + ADDR_W'(1);
          end
        end
        ST_WDATA: begin
          if (w_rise) begin
            r_phase <= ~r_phase;
            if (!r_phase) r_wnib <= i_qspi_d_in;
            else          r_addr <= r_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase

      // Drive only while staying in RDATA; any exit releases the bus next clk.
      if (w_state_nxt != ST_RDATA) begin
        r_oe   <= 1'b0;
        r_dout <= 4'd0;
      end else if (r_state == ST_RDATA && w_fall) begin
        r_oe   <= 1'b1;
        r_dout <= r_phase ? w_rd_data[3:0] : w_rd_data[7:4];
      end
    end
  end

  qspi_emu_mem #(
    .NUM_CS (NUM_CS),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk        (clk),
    .i_rd_sel   (r_dev),
    .i_rd_addr  (r_addr),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_wr_en),
    .i_wr_sel   (r_dev),
    .i_wr_addr  (r_addr),
    .i_wr_data  (w_wr_data),
    .i_bd_we    (i_bd_we),
    .i_bd_sel   (i_bd_sel),
    .i_bd_addr  (i_bd_addr),
    .i_bd_wdata (i_bd_wdata)
  );

  assign o_qspi_d_out = r_dout;
  assign o_qspi_d_oe  = r_oe;
  assign o_proto_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_qspi_mem_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_qspi_mem_emu
// Brief    : Host-side QSPI driver with a byte-array model of each device.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qspi_mem_emu;

  localparam int NUM_CS = 3;
  localparam int ADDR_W = 12;
  localparam int FLASH_DUMMY = 4;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int HP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck;
  logic [2:0]  cs_n;
  logic [3:0]  d_in;
  logic [3:0]  d_out;
  logic        oe;
  logic [2:0]  lat;
  logic        bd_we;
  logic [1:0]  bd_sel;
  logic [11:0] bd_addr;
  logic [7:0]  bd_wdata;
  logic        perr;

  int total = 0;
  int bad = 0;
  logic [7:0] ref_mem [NUM_CS][DEPTH];

  always #5 clk = ~clk;

  qspi_mem_emu #(
    .NUM_CS(NUM_CS), .ADDR_W(ADDR_W), .FLASH_DUMMY(FLASH_DUMMY)
  ) dut (
    .clk(clk), .rst(rst), .i_qspi_sck(sck), .i_qspi_cs_n(cs_n),
    .i_qspi_d_in(d_in), .o_qspi_d_out(d_out), .o_qspi_d_oe(oe),
    .i_latency_cfg(lat), .i_bd_we(bd_we), .i_bd_sel(bd_sel),
    .i_bd_addr(bd_addr), .i_bd_wdata(bd_wdata), .o_proto_err(perr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input int s, input int a, input logic [7:0] v);
    bd_we = 1'b1; bd_sel = 2'(s); bd_addr = 12'(a); bd_wdata = v;
    @(negedge clk);
    bd_we = 1'b0;
    if (s < NUM_CS) ref_mem[s][a] = v;
  endtask

  // One host SCK period: data set while low, bus sampled just before the rise.
  task automatic sck_cycle(input logic [3:0] nib, output logic [3:0] dq, output logic e);
    d_in = nib;
    repeat (HP) @(negedge clk);
    dq = d_out; e = oe;
    sck = 1'b1;
    repeat (HP) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic cs_select(input int dev, input int lat_v);
    lat = 3'(lat_v);
    cs_n = 3'(~(3'b001 << dev));
    repeat (2) @(negedge clk);
  endtask

  task automatic end_txn(input string tag);
    repeat (2) @(negedge clk);
    cs_n = 3'b111;
    @(negedge clk);
    check({tag, " oe after deselect"}, oe, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a, input int ndum, input string tag);
    logic [3:0] dq;
    logic e;
    for (int i = 0; i < 2; i++) begin
      sck_cycle(cmd[7-4*i -: 4], dq, e);
      check({tag, " oe cmd"}, e, 0);
    end
    for (int i = 0; i < 6; i++) begin
      sck_cycle(a[23-4*i -: 4], dq, e);
      check({tag, " oe addr"}, e, 0);
    end
    for (int i = 0; i < ndum; i++) begin
      sck_cycle(4'($urandom), dq, e);
      check({tag, " oe dummy"}, e, 0);
    end
  endtask

  task automatic read_txn(input int dev, input logic [23:0] a, input int lat_v, input int nb, input string tag);
    logic [3:0] hi, lo;
    logic e;
    int wa;
    cs_select(dev, lat_v);
    send_hdr(8'hEB, a, (dev == 0) ? FLASH_DUMMY : lat_v, tag);
    wa = int'(a[11:0]);
    for (int i = 0; i < nb; i++) begin
      sck_cycle(4'($urandom), hi, e);
      check({tag, " oe data hi"}, e, 1);
      sck_cycle(4'($urandom), lo, e);
      check({tag, " oe data lo"}, e, 1);
      check({tag, " byte"}, {hi, lo}, ref_mem[dev][wa]);
      wa = (wa + 1) % DEPTH;
    end
    end_txn(tag);
  endtask

  task automatic write_txn(input int dev, input logic [23:0] a, input int lat_v, input int nb, input bit half, input string tag);
    logic [3:0] dq;
    logic e;
    logic [7:0] b;
    int wa;
    cs_select(dev, lat_v);
    send_hdr(8'h02, a, 0, tag);
    wa = int'(a[11:0]);
    for (int i = 0; i < nb; i++) begin
      b = 8'($urandom);
      sck_cycle(b[7:4], dq, e);
      check({tag, " oe wr"}, e, 0);
      sck_cycle(b[3:0], dq, e);
      check({tag, " oe wr"}, e, 0);
      if (dev != 0) ref_mem[dev][wa] = b;
      wa = (wa + 1) % DEPTH;
    end
    if (half) sck_cycle(4'($urandom), dq, e);
    end_txn(tag);
  endtask

  initial begin
    logic [3:0] dq;
    logic e;
    rst = 1'b1; sck = 1'b0; cs_n = 3'b111; d_in = 4'd0; lat = 3'd0;
    bd_we = 1'b0; bd_sel = 2'd0; bd_addr = 12'd0; bd_wdata = 8'd0;
    repeat (3) @(negedge clk);
    check("reset oe", oe, 0);
    check("reset dout", d_out, 0);
    check("reset perr", perr, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int s = 0; s < NUM_CS; s++)
      for (int a = 0; a < DEPTH; a++)
        bd_write(s, a, 8'($urandom));

    // Flash read with the default dummy count.
    bd_write(0, 12'h010, 8'hA5);
    bd_write(0, 12'h011, 8'h3C);
    read_txn(0, 24'h000010, 0, 2, "flash rd");

    // RAM write across the top-of-array wrap, then readback.
    write_txn(1, 24'h000FFF, 2, 0, 0, "wrap wr0");
    cs_select(1, 2);
    send_hdr(8'h02, 24'h000FFF, 0, "wrap wr");
    sck_cycle(4'h1, dq, e); sck_cycle(4'h1, dq, e);
    sck_cycle(4'h2, dq, e); sck_cycle(4'h2, dq, e);
    ref_mem[1][12'hFFF] = 8'h11;
    ref_mem[1][0] = 8'h22;
    end_txn("wrap wr");
    read_txn(1, 24'h000FFF, 2, 2, "wrap rd");

    // Write command aimed at flash is accepted but changes nothing.
    bd_write(0, 0, 8'h5A);
    cs_select(0, 0);
    send_hdr(8'h02, 24'h000000, 0, "flash wr");
    sck_cycle(4'hF, dq, e); sck_cycle(4'hF, dq, e);
    end_txn("flash wr");
    read_txn(0, 24'h000000, 0, 1, "flash chk");
    check("flash wr perr", perr, 0);

    // Write abandoned after one nibble of its second byte.
    write_txn(1, 24'hAB0123, 3, 1, 1, "abort wr");
    read_txn(1, 24'h000123, 3, 2, "abort chk");

    // Read abandoned mid-byte: bus released on the clk after deselect.
    cs_select(2, 1);
    send_hdr(8'hEB, 24'h000200, 1, "rd abort");
    sck_cycle(4'h0, dq, e);
    check("rd abort oe", e, 1);
    check("rd abort hi", dq, 32'(ref_mem[2][12'h200] >> 4));
    cs_n = 3'b111;
    @(negedge clk);
    check("rd abort oe drop", oe, 0);
    repeat (2) @(negedge clk);

    for (int t = 0; t < 30; t++) begin
      int dv, nb, lv;
      logic [23:0] a;
      bit wr;
      dv = $urandom_range(0, 2);
      nb = $urandom_range(1, 5);
      lv = $urandom_range(0, 7);
      a = 24'($urandom);
      if ($urandom_range(0, 3) == 0) a[11:0] = 12'hFFF - 12'($urandom_range(0, 3));
      wr = (dv == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
      if (wr) write_txn(dv, a, lv, nb, 1'b0, "rnd wr");
      else    read_txn(dv, a, lv, nb, "rnd rd");
    end
    check("rnd perr", perr, 0);

    // Unknown command on a RAM select.
    cs_select(2, 0);
    sck_cycle(4'h9, dq, e); sck_cycle(4'hF, dq, e);
    for (int i = 0; i < 8; i++) begin
      sck_cycle(4'($urandom), dq, e);
      check("badcmd oe", e, 0);
    end
    check("badcmd perr", perr, 1);
    end_txn("badcmd");

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rerst perr", perr, 0);

    // Two selects at once, then recovery.
    cs_n = 3'b001;
    repeat (2) @(negedge clk);
    check("multi perr", perr, 1);
    for (int i = 0; i < 12; i++) begin
      sck_cycle((i == 0) ? 4'hE : ((i == 1) ? 4'hB : 4'($urandom)), dq, e);
      check("multi oe", e, 0);
    end
    end_txn("multi");
    read_txn(2, 24'h000040, 3, 3, "recover rd");
    check("recover perr", perr, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qspi_mem_emu.md
Name: qspi_mem_emu

Overview:
- Synthesizable QSPI memory emulator for the tinyQV bench and FPGA bring-up boards, the next generation of the bench's fixed flash + RAM A/B pin wiring.
- Parametrised in select count and memory depth. Select 0 is the read-only flash; selects 1..NUM_CS-1 are read/write RAMs.
- Oversamples the QSPI pins on the system clock, decodes quad command/address/dummy/data phases, and drives read data back.
- Sits between the tinyQV QSPI pins and bench-side memory. A backdoor port preloads images.

Parameters:
- NUM_CS, 3, number of chip selects (1 flash + NUM_CS-1 RAMs), range 1..4.
- ADDR_W, 12, byte address width per device; each device holds 2^ADDR_W bytes.
- FLASH_DUMMY, 4, dummy SCK cycles after the address for select 0.

Ports:
- clk  in  1  system clock; must be ≥4x the QSPI SCK rate.
- rst  in  1  asynchronous, active-high reset.
- qspi_sck  in  1  QSPI clock from the host.
- qspi_cs_n  in  NUM_CS  active-low selects; bit 0 is flash.
- qspi_d_in  in  4  host-driven data nibble.
- qspi_d_out  out  4  emulator-driven data nibble.
- qspi_d_oe  out  1  high when the emulator drives qspi_d_out.
- latency_cfg  in  3  RAM dummy cycle count, sampled when CS falls.
- bd_we  in  1  backdoor byte write strobe.
- bd_sel  in  2  backdoor target device.
- bd_addr  in  ADDR_W  backdoor byte address.
- bd_wdata  in  8  backdoor write data.
- proto_err  out  1  sticky protocol error flag; cleared only by rst.

Behaviour:
- Reset values: qspi_d_out=0, qspi_d_oe=0, proto_err=0, FSM=IDLE. Memory contents are not reset.
- Edge detection: sck_q registers qspi_sck. Rise = sck & ~sck_q; fall = ~sck & sck_q. All pins are treated as synchronous to clk.
- Sampling and driving: inputs are sampled on rise. Outputs update on the clk edge after a detected fall, i.e. one clk of latency.
- Nibble order: high nibble first everywhere.
- FSM states: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, ERR.
- IDLE -> CMD: exactly one cs_n bit goes low. Latch the device index. Latch the dummy count: FLASH_DUMMY for device 0, latency_cfg for RAM devices.
- IDLE -> ERR: two or more cs_n bits go low. Set proto_err.
- CMD: 2 rises capture the 8-bit command.
  - 0xEB -> ADDR (read).
  - 0x02 -> ADDR (write) on a RAM device.
  - 0x02 on flash -> ADDR, but the write is ignored (memory unchanged, no error).
  - Any other command -> ERR and set proto_err.
- ADDR: 6 rises capture 24 address bits. Only the low ADDR_W bits are used; upper bits are ignored.
- ADDR exit, read: go to DUMMY if the dummy count > 0, else RDATA.
- ADDR exit, write: go to WDATA (no dummy cycles).
- DUMMY: count the dummy rises. The count reaching 0 moves to RDATA.
- RDATA:
  - oe asserts at the first fall after entry, driving the high nibble of mem[addr].
  - The next fall drives the low nibble.
  - Then addr increments and the next byte follows.
  - Address wraps from 2^ADDR_W-1 to 0.
- WDATA: two rises assemble a byte, which is written at the second rise; then addr increments with the same wrap.
- Deselect: a rise of the active cs_n in any state returns to IDLE; oe drops on the next clk.
  - A half-assembled write byte is discarded.
  - Deselect during CMD/ADDR is not an error.
- ERR: oe held at 0. Return to IDLE once all cs_n are high.
- Selection changes: any other cs_n bit falling while a device is active -> ERR and proto_err.
- Backdoor: bd_we writes mem[bd_sel][bd_addr] at the clk edge; bd_sel ≥ NUM_CS is ignored.
  - A backdoor write and a QSPI write to the same byte in the same cycle: the QSPI write wins.

Decomposition:
- Shared package qspi_emu_pkg:
  - state enum;
  - command constants CMD_READ_QUAD=8'hEB, CMD_WRITE_QUAD=8'h02;
  - phase lengths CMD_NIBBLES=2, ADDR_NIBBLES=6.
- One sub-module, qspi_emu_mem:
  - NUM_CS x 2^ADDR_W byte array;
  - one read port and one write port;
  - arbitrates backdoor vs QSPI writes.

Test Plan:
- Backdoor write dev0 0x010=0xA5, 0x011=0x3C; QSPI 0xEB to addr 0x000010 with 4 dummy -> oe rises at first fall after dummy; nibbles A,5,3,C.
- latency_cfg=2, cs1, write 0x02 addr 0x000FFF with data 0x11,0x22 -> dev1[0xFFF]=0x11, dev1[0x000]=0x22 (wrap); readback with 2 dummy returns 11,22.
- cs0 write 0x02 addr 0 data 0xFF -> dev0[0] unchanged, proto_err=0.
- cs1 and cs2 low together -> proto_err=1, oe=0 throughout; after all cs_n high, a normal read on cs2 succeeds.
- cs1 raised after the first write nibble -> byte not written; oe=0 one clk after deselect; FSM in IDLE.
- Command 0x9F on cs2 -> ERR, proto_err=1, no data driven until deselect.
